// File: rtl/regfile_hazard_ctrl.sv
// Scoreboard hazard/stall controller for the 32x32 register file.
// Counts in-flight writes per register, stalls decode on RAW or saturation, and sequences the post-reset RF clear.
module regfile_hazard_ctrl #(
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned NREG       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic            id_use_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_wen,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            wb_wen,
  input  logic            kill_valid,
  input  logic [4:0]      kill_rd,
  input  logic            kill_wen,
  output logic            stall,
  output logic            rf_rst,
  output logic [NREG-1:0] pending,
  output logic [31:0]     stall_cnt,
  output logic            err
);

  localparam int unsigned AW = 5;
  localparam int unsigned IW = $clog2(RST_CYCLES + 1);
  localparam int unsigned SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [IW-1:0]    init_cnt;
  logic             init_active;
  logic             raw1, raw2, full;
  logic             issue, retire, squash;
  logic             event_err;
  logic [SW-1:0]    sum;
  logic [1:0]       dec;

  assign init_active = (init_cnt != '0);

  // Hazard detection against the pre-edge counts; a same-cycle WB does not unblock a reader.
  assign raw1  = id_use_rs1 && (id_rs1 != '0) && (cnt[id_rs1] != '0);
  assign raw2  = id_use_rs2 && (id_rs2 != '0) && (cnt[id_rs2] != '0);
  assign full  = id_wen && (id_rd != '0) && (cnt[id_rd] == CNT_MAX);
  assign stall = init_active || (id_valid && (raw1 || raw2 || full));

  assign issue  = id_valid && !stall && id_wen && (id_rd != '0);
  assign retire = wb_valid && wb_wen && (wb_rd != '0);
  assign squash = kill_valid && kill_wen && (kill_rd != '0);

  // Per-register net update: +issue -retire -squash, clamped to the counter range.
  always_comb begin
    event_err = 1'b0;
    sum       = '0;
    dec       = '0;
    for (int unsigned i = 0; i < NREG; i++) cnt_nxt[i] = cnt[i];
    if (init_active) begin
      event_err = retire || squash;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        sum = SW'(cnt[i]) + SW'(issue && (id_rd == AW'(i)));
        dec = 2'(retire && (wb_rd == AW'(i))) + 2'(squash && (kill_rd == AW'(i)));
        if (sum < SW'(dec)) begin
          cnt_nxt[i] = '0;
          event_err  = 1'b1;
        end else if ((sum - SW'(dec)) > SW'(CNT_MAX)) begin
          cnt_nxt[i] = CNT_MAX;
          event_err  = 1'b1;
        end else begin
          cnt_nxt[i] = CNT_W'(sum - SW'(dec));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) cnt[i] <= '0;
      init_cnt  <= IW'(RST_CYCLES);
      rf_rst    <= 1'b1;
      pending   <= '0;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
      if (init_active) init_cnt <= init_cnt - IW'(1);
      // High while the post-edge init count is still nonzero.
      rf_rst     <= (init_cnt > IW'(1));
      pending[0] <= 1'b0;
      for (int unsigned i = 1; i < NREG; i++) pending[i] <= (cnt_nxt[i] != '0);
      if (stall && id_valid && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (event_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_hazard_ctrl.sv
// Self-checking bench for regfile_hazard_ctrl: directed vector table plus randomized traffic against a scoreboard model.
module tb_regfile_hazard_ctrl;

  localparam int MAXC = 3;
  localparam int RC   = 2;

  typedef struct {
    logic       idv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wen;
    logic       wbv;
    logic [4:0] wbrd;
    logic       wbw;
    logic       kv;
    logic [4:0] krd;
    logic       kw;
    logic       e_stall;
    logic       e_rf;
    logic [31:0] e_pend;
    logic       e_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid, id_use_rs1, id_use_rs2, id_wen;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        wb_valid, wb_wen, kill_valid, kill_wen;
  logic [4:0]  wb_rd, kill_rd;
  logic        stall, rf_rst, err;
  logic [31:0] pending, stall_cnt;

  regfile_hazard_ctrl #(.CNT_W(2), .RST_CYCLES(RC), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_use_rs1(id_use_rs1),
    .id_rs2(id_rs2), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .kill_valid(kill_valid), .kill_rd(kill_rd), .kill_wen(kill_wen),
    .stall(stall), .rf_rst(rf_rst), .pending(pending),
    .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          m_cnt [32];
  int          m_init;
  bit          m_err;
  logic [31:0] m_sc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic idv, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rd, input logic wen,
                              input logic wbv, input logic [4:0] wbrd,
                              input logic kv, input logic [4:0] krd,
                              input logic es, input logic erf, input logic [31:0] ep, input logic ee);
    vec_t v;
    v.idv = idv; v.rs1 = rs1; v.u1 = u1; v.rs2 = 5'd0; v.u2 = 1'b0;
    v.rd = rd; v.wen = wen;
    v.wbv = wbv; v.wbrd = wbrd; v.wbw = wbv;
    v.kv = kv; v.krd = krd; v.kw = kv;
    v.e_stall = es; v.e_rf = erf; v.e_pend = ep; v.e_err = ee;
    return v;
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] p;
    p = '0;
    for (int i = 1; i < 32; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_init = RC;
    m_err  = 1'b0;
    m_sc   = '0;
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.idv; id_rs1 = v.rs1; id_use_rs1 = v.u1;
    id_rs2 = v.rs2; id_use_rs2 = v.u2; id_rd = v.rd; id_wen = v.wen;
    wb_valid = v.wbv; wb_rd = v.wbrd; wb_wen = v.wbw;
    kill_valid = v.kv; kill_rd = v.krd; kill_wen = v.kw;
  endtask

  // Called at a falling edge; applies one vector across one rising edge and ends at the next falling edge.
  task automatic cycle(input vec_t v, input bit use_tbl);
    bit raw1, raw2, full, s, issue, ret, sq;
    int d [32];
    int n;
    drive(v);
    #1;
    raw1 = v.u1 && (v.rs1 != 0) && (m_cnt[v.rs1] > 0);
    raw2 = v.u2 && (v.rs2 != 0) && (m_cnt[v.rs2] > 0);
    full = v.wen && (v.rd != 0) && (m_cnt[v.rd] == MAXC);
    s    = (m_init > 0) || (v.idv && (raw1 || raw2 || full));
    chk("stall", 32'(stall), 32'(s));
    if (use_tbl) chk("tbl_stall", 32'(stall), 32'(v.e_stall));
    issue = v.idv && !s && v.wen && (v.rd != 0);
    ret   = v.wbv && v.wbw && (v.wbrd != 0);
    sq    = v.kv && v.kw && (v.krd != 0);
    @(posedge clk);
    if (m_init > 0) begin
      if (ret || sq) m_err = 1'b1;
      m_init--;
    end else begin
      for (int i = 0; i < 32; i++) d[i] = 0;
      if (issue) d[v.rd]++;
      if (ret)   d[v.wbrd]--;
      if (sq)    d[v.krd]--;
      for (int i = 1; i < 32; i++) begin
        n = m_cnt[i] + d[i];
        if (n < 0)    begin n = 0;    m_err = 1'b1; end
        if (n > MAXC) begin n = MAXC; m_err = 1'b1; end
        m_cnt[i] = n;
      end
    end
    if (s && v.idv && (m_sc != 32'hFFFF_FFFF)) m_sc = m_sc + 32'd1;
    #1;
    chk("rf_rst", 32'(rf_rst), 32'(m_init > 0));
    chk("pending", pending, m_pend());
    chk("err", 32'(err), 32'(m_err));
    chk("stall_cnt", stall_cnt, m_sc);
    if (use_tbl) begin
      chk("tbl_rf_rst", 32'(rf_rst), 32'(v.e_rf));
      chk("tbl_pending", pending, v.e_pend);
      chk("tbl_err", 32'(err), 32'(v.e_err));
    end
    @(negedge clk);
  endtask

  // Asserts reset between clock edges, checks the immediate clear, and releases on a falling edge.
  task automatic async_reset();
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_rf_rst", 32'(rf_rst), 32'd1);
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_pending", pending, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t        tbl [$];
  vec_t        v;
  vec_t        idle;
  logic [31:0] sc_before;
  int          r;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    model_reset();

    // idv rs1 u1 rd wen | wbv wbrd | kv krd | stall rf pend err
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0,  1, 1, 32'h0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0,  1, 0, 32'h0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 0, 5, 1,  0, 0,  0, 0,  0, 0, 32'h20, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0,  0, 0,  0, 0,  1, 0, 32'h20, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0,  1, 5,  0, 0,  1, 0, 32'h0,  0));
    tbl.push_back(mk(1, 5, 1, 0, 0,  0, 0,  0, 0,  0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 0, 7, 1,  0, 0,  0, 0,  0, 0, 32'h80, 0));
    tbl.push_back(mk(1, 0, 0, 7, 1,  0, 0,  0, 0,  0, 0, 32'h80, 0));
    tbl.push_back(mk(1, 0, 0, 7, 1,  0, 0,  0, 0,  0, 0, 32'h80, 0));
    tbl.push_back(mk(1, 0, 0, 7, 1,  0, 0,  0, 0,  1, 0, 32'h80, 0));
    tbl.push_back(mk(1, 0, 0, 7, 1,  1, 7,  0, 0,  1, 0, 32'h80, 0));
    tbl.push_back(mk(1, 0, 0, 7, 1,  0, 0,  0, 0,  0, 0, 32'h80, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 7,  0, 0,  0, 0, 32'h80, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 7,  0, 0,  0, 0, 32'h80, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 7,  0, 0,  0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 0, 3, 1,  0, 0,  0, 0,  0, 0, 32'h8,  0));
    tbl.push_back(mk(1, 0, 0, 3, 1,  1, 3,  1, 3,  0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  0, 0,  0, 0,  0, 0, 32'h0,  0));
    tbl.push_back(mk(1, 0, 1, 0, 1,  0, 0,  0, 0,  0, 0, 32'h0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 9,  0, 0,  0, 0, 32'h0,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 32'h0,  1));

    async_reset();
    foreach (tbl[i]) cycle(tbl[i], 1'b1);

    // Ten back-to-back stalled decode cycles on a pending source.
    cycle(mk(1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 32'h400, 1), 1'b1);
    sc_before = m_sc;
    for (int i = 0; i < 10; i++) cycle(mk(1, 10, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h400, 1), 1'b1);
    chk("stall_cnt_plus10", stall_cnt, sc_before + 32'd10);
    cycle(mk(0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 32'h0, 1), 1'b1);

    // Mid-run reset with a pending write, then a retire during init.
    cycle(mk(1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 32'h1000, 1), 1'b1);
    async_reset();
    cycle(mk(0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 1, 32'h0, 1), 1'b1);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1), 1'b1);

    // Randomized traffic against the scoreboard model.
    async_reset();
    cycle(idle, 1'b0);
    cycle(idle, 1'b0);
    for (int k = 0; k < 1500; k++) begin
      v = idle;
      v.idv = ($urandom % 4) != 0;
      v.rs1 = 5'($urandom % 8);
      v.u1  = 1'($urandom % 2);
      v.rs2 = 5'($urandom % 8);
      v.u2  = 1'($urandom % 2);
      v.rd  = 5'($urandom % 8);
      v.wen = 1'($urandom % 2);
      r = 1 + int'($urandom % 7);
      v.wbrd = 5'(r);
      v.wbw  = 1'b1;
      v.wbv  = ($urandom % 3) == 0;
      if (m_cnt[r] == 0 && ($urandom % 50) != 0) v.wbv = 1'b0;
      r = 1 + int'($urandom % 7);
      v.krd = 5'(r);
      v.kw  = 1'b1;
      v.kv  = ($urandom % 6) == 0;
      if (m_cnt[r] == 0 && ($urandom % 50) != 0) v.kv = 1'b0;
      cycle(v, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
